// File: rtl/vigna_mdu.sv
// vigna_mdu: iterative RV32M multiply/divide unit.
//
// Multiplies by shift-add into a 2*XLEN accumulator and divides by
// restoring shift-subtract, retiring BITS_PER_CYCLE bits per CALC cycle.
// Operands are converted to magnitudes on accept and the recorded result
// sign is applied in a single FIX cycle. Divide-by-zero and signed
// overflow are resolved on the accept edge and skip CALC/FIX entirely.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_op                 RV32M funct3
//   req_a, req_b           rs1 / rs2 operands
//   req_rd                 destination tag, returned on resp_rd
//   flush                  abort the in-flight operation (ignored in IDLE)
//   resp_valid/resp_ready  response handshake
//   resp_data, resp_rd     result and its tag, held stable until taken
//   busy                   high whenever not IDLE
module vigna_mdu #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            busy
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]      op;
  logic [4:0]      rd;
  logic            neg;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, opb;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction

  // Accept-time operand decode
  logic                   accept, is_div, a_signed, b_signed, sa, sb;
  logic                   div_zero, div_ovf, special, sign_acc;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN-1:0]        mag_a, mag_b, special_data;

  assign accept   = req_valid && (state == IDLE) && !flush;
  assign is_div   = req_op[2];
  assign a_s      = req_a;
  assign b_s      = req_b;
  assign a_signed = (req_op == 3'b001) || (req_op == 3'b010) ||
                    (req_op == 3'b100) || (req_op == 3'b110);
  assign b_signed = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
  assign sa       = a_signed && (a_s < 0);
  assign sb       = b_signed && (b_s < 0);
  assign mag_a    = cond_neg(req_a, sa);
  assign mag_b    = cond_neg(req_b, sb);
  // REM/REMU take the dividend's sign; everything else takes sa^sb
  assign sign_acc = (is_div && req_op[1]) ? sa : (sa ^ sb);

  assign div_zero = is_div && (req_b == '0);
  assign div_ovf  = is_div && !req_op[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
  assign special  = div_zero || div_ovf;
  // Overflow quotient equals the dividend (most negative value)
  always_comb begin
    special_data = '0;
    if (div_zero) special_data = req_op[1] ? req_a : '1;
    else          special_data = req_op[1] ? '0 : req_a;
  end

  // CALC iteration: BITS_PER_CYCLE shift-add or shift-subtract steps
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic [XLEN:0]   sh, diff, sum;

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    sh     = '0;
    diff   = '0;
    sum    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op[2]) begin
        // Partial remainder stays below the divisor, so sh < 2*divisor
        // and the borrow bit alone decides the quotient bit.
        sh   = {hi_nxt, lo_nxt[XLEN-1]};
        diff = sh - {1'b0, opb};
        if (!diff[XLEN]) begin
          hi_nxt = diff[XLEN-1:0];
          lo_nxt = {lo_nxt[XLEN-2:0], 1'b1};
        end else begin
          hi_nxt = sh[XLEN-1:0];
          lo_nxt = {lo_nxt[XLEN-2:0], 1'b0};
        end
      end else begin
        sum    = {1'b0, hi_nxt} + (lo_nxt[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        hi_nxt = sum[XLEN:1];
        lo_nxt = {sum[0], lo_nxt[XLEN-1:1]};
      end
    end
  end

  // FIX: sign correction and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   result;

  assign prod_fix = cond_neg_wide({hi, lo}, neg);

  always_comb begin
    result = '0;
    case (op)
      3'b000:                 result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = cond_neg(lo, neg);
      default:                result = cond_neg(hi, neg);
    endcase
  end

  // Control FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)                        state_nxt = special ? DONE : CALC;
      CALC: if (flush)                         state_nxt = IDLE;
            else if (cnt == CW'(N - 1))        state_nxt = FIX;
      FIX:  state_nxt = flush ? IDLE : DONE;
      DONE: if (flush || resp_ready)           state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  // Datapath and response registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op         <= '0;
      rd         <= '0;
      neg        <= 1'b0;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      opb        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op  <= req_op;
          rd  <= req_rd;
          neg <= sign_acc;
          cnt <= '0;
          hi  <= '0;
          lo  <= is_div ? mag_a : mag_b;
          opb <= is_div ? mag_b : mag_a;
          if (special) begin
            resp_valid <= 1'b1;
            resp_data  <= special_data;
            resp_rd    <= req_rd;
          end
        end
        CALC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: if (!flush) begin
          resp_valid <= 1'b1;
          resp_data  <= result;
          resp_rd    <= rd;
        end
        DONE: if (flush || resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_vigna_mdu.sv
// tb_vigna_mdu: bench for vigna_mdu. Three instances (BITS_PER_CYCLE 1, 2, 4)
// share the request payload, flush and reset; each has its own
// req_valid/resp_ready so only one is driven at a time.
module tb_vigna_mdu;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic [2:0]  rv, rr, rdy, vld, bsy;
  logic [31:0] rdata [3];
  logic [4:0]  rrd [3];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vigna_mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .resetn(resetn), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .flush(flush), .resp_valid(vld[0]), .resp_ready(rr[0]),
    .resp_data(rdata[0]), .resp_rd(rrd[0]), .busy(bsy[0]));

  vigna_mdu #(.XLEN(32), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .resetn(resetn), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .flush(flush), .resp_valid(vld[1]), .resp_ready(rr[1]),
    .resp_data(rdata[1]), .resp_rd(rrd[1]), .busy(bsy[1]));

  vigna_mdu #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .resetn(resetn), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .flush(flush), .resp_valid(vld[2]), .resp_ready(rr[2]),
    .resp_data(rdata[2]), .resp_rd(rrd[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] as64, bs64, bu64, ps;
    logic [63:0]        pu;
    int                 ia, ib;
    as64 = 64'($signed(a));
    bs64 = 64'($signed(b));
    bu64 = {32'b0, b};
    pu   = {32'b0, a} * {32'b0, b};
    ia   = a;
    ib   = b;
    case (op)
      3'd0: return pu[31:0];
      3'd1: begin ps = as64 * bs64; return ps[63:32]; end
      3'd2: begin ps = as64 * bu64; return ps[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit spec;
    spec = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return spec ? 1 : (32 / (1 << w)) + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Issue one request to instance w (idle, called at #1 after an edge),
  // count edges from accept (inclusive) until resp_valid, then take it.
  task automatic run_op(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] data, output logic [4:0] trd, output int lat);
    req_op = op; req_a = a; req_b = b; req_rd = rd;
    rv[w] = 1'b1; rr[w] = 1'b1;
    @(posedge clk); #1;
    rv[w]  = 1'b0;
    req_a  = $urandom();
    req_b  = $urandom();
    req_op = 3'($urandom());
    req_rd = 5'($urandom());
    lat = 1;
    while (!vld[w] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    data = rdata[w];
    trd  = rrd[w];
    @(posedge clk); #1;
    rr[w] = 1'b0;
  endtask

  task automatic op_check(input string tag, input int w, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] d;
    logic [4:0]  t;
    int          l;
    run_op(w, op, a, b, rd, d, t, l);
    chk({tag, " data"}, 64'(d), 64'(ref_model(op, a, b)));
    chk({tag, " tag"},  64'(t), 64'(rd));
    chk({tag, " lat"},  64'(l), 64'(exp_lat(w, op, a, b)));
  endtask

  initial begin
    logic [31:0] a, b, d0;
    logic [4:0]  t0;
    logic [2:0]  op;
    bit          seen;
    int          lat;

    resetn = 1'b0; flush = 1'b0; rv = '0; rr = '0;
    req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 64'(rdy[0]), 64'd1);
    chk("reset resp_valid", 64'(vld[0]), 64'd0);
    chk("reset resp_data", 64'(rdata[0]), 64'd0);
    chk("reset resp_rd", 64'(rrd[0]), 64'd0);
    chk("reset busy", 64'(bsy[0]), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic with hand-computed results
    run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd17, d0, t0, lat);
    chk("mul7 data", 64'(d0), 64'hFFFF_FFEB);
    chk("mul7 tag", 64'(t0), 64'd17);
    chk("mul7 lat", 64'(lat), 64'd34);
    run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, d0, t0, lat);
    chk("mulh min", 64'(d0), 64'h4000_0000);
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, d0, t0, lat);
    chk("mulhsu -1", 64'(d0), 64'hFFFF_FFFF);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, d0, t0, lat);
    chk("mulhu max", 64'(d0), 64'hFFFF_FFFE);
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, d0, t0, lat);
    chk("div -7/2", 64'(d0), 64'hFFFF_FFFD);
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, d0, t0, lat);
    chk("rem -7/2", 64'(d0), 64'hFFFF_FFFF);
    run_op(0, 3'd5, 32'd100, 32'd7, 5'd6, d0, t0, lat);
    chk("divu 100/7", 64'(d0), 64'd14);
    run_op(0, 3'd7, 32'd100, 32'd7, 5'd7, d0, t0, lat);
    chk("remu 100/7", 64'(d0), 64'd2);

    // Special cases: result one edge after accept
    run_op(0, 3'd5, 32'h1234, 32'd0, 5'd8, d0, t0, lat);
    chk("divu by 0", 64'(d0), 64'hFFFF_FFFF);
    chk("divu by 0 lat", 64'(lat), 64'd1);
    run_op(0, 3'd6, 32'h1234, 32'd0, 5'd9, d0, t0, lat);
    chk("rem by 0", 64'(d0), 64'h1234);
    chk("rem by 0 tag", 64'(t0), 64'd9);
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, d0, t0, lat);
    chk("div ovf", 64'(d0), 64'h8000_0000);
    chk("div ovf lat", 64'(lat), 64'd1);
    run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, d0, t0, lat);
    chk("rem ovf", 64'(d0), 64'd0);

    // Backpressure
    req_op = 3'd0; req_a = 32'd6; req_b = 32'd9; req_rd = 5'd21; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0; req_a = $urandom(); req_rd = 5'd0;
    lat = 1;
    while (!vld[0] && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp valid", 64'(vld[0]), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp hold", {24'd0, bsy[0], rdy[0], vld[0], rrd[0], rdata[0]}, {24'd0, 1'b1, 1'b0, 1'b1, 5'd21, 32'd54});
    end
    rr[0] = 1'b1;
    @(posedge clk); #1;
    rr[0] = 1'b0;
    chk("bp release valid", 64'(vld[0]), 64'd0);
    chk("bp release ready", 64'(rdy[0]), 64'd1);

    // Flush in CALC cycle 10
    req_op = 3'd0; req_a = 32'd9; req_b = 32'd9; req_rd = 5'd3; rv[0] = 1'b1; rr[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("flush pre busy", 64'(bsy[0]), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush state", {61'd0, bsy[0], rdy[0], vld[0]}, {61'd0, 1'b0, 1'b1, 1'b0});
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (vld[0]) seen = 1'b1; end
    chk("flush no resp", 64'(seen), 64'd0);
    rr[0] = 1'b0;
    op_check("post flush mul", 0, 3'd0, 32'd3, 32'd5, 5'd12);

    // Flush wins over a simultaneous request in IDLE
    req_op = 3'd0; req_a = 32'd2; req_b = 32'd2; rv[0] = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0; flush = 1'b0;
    chk("flush prio busy", 64'(bsy[0]), 64'd0);

    // Asynchronous reset mid-CALC
    req_op = 3'd1; req_a = 32'h1357_9BDF; req_b = 32'h2468_ACE0; rv[0] = 1'b1; rr[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async rst state", {61'd0, bsy[0], rdy[0], vld[0]}, {61'd0, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (vld[0] || bsy[0]) seen = 1'b1; end
    chk("rst no resp", 64'(seen), 64'd0);
    rr[0] = 1'b0;
    op_check("post rst mul", 0, 3'd0, 32'd3, 32'd5, 5'd13);

    // Wider radix latency
    run_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd14, d0, t0, lat);
    chk("bpc2 data", 64'(d0), 64'hFFFF_FFEB);
    chk("bpc2 lat", 64'(lat), 64'd18);
    run_op(2, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd15, d0, t0, lat);
    chk("bpc4 data", 64'(d0), 64'hFFFF_FFEB);
    chk("bpc4 lat", 64'(lat), 64'd10);

    // Randomized operations against the model on all three radices
    for (int i = 0; i < 80; i++) begin
      int w;
      w  = (i < 40) ? 0 : ((i < 60) ? 1 : 2);
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      op_check($sformatf("rnd%0d w%0d op%0d", i, w, op), w, op, a, b, 5'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vigna_mdu.md
Name: vigna_mdu

Overview:
- Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the vigna core family.
- Parametrised in operand width and radix (bits retired per cycle).
- Sits beside the integer ALU in the execute stage. The core issues an operation with a valid/ready request and collects the result through a valid/ready response carrying the destination-register tag.

Parameters:
- XLEN, 32, operand and result width; must be even and at least 8.
- BITS_PER_CYCLE, 1, quotient/multiplier bits processed per CALC cycle; legal values 1, 2, 4; must divide XLEN.
- N (localparam), XLEN/BITS_PER_CYCLE, number of CALC cycles.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  in  XLEN  rs1 operand (dividend / multiplicand).
- req_b  in  XLEN  rs2 operand (divisor / multiplier).
- req_rd  in  5  destination tag, returned unchanged.
- flush  in  1  abort any in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  XLEN  result.
- resp_rd  out  5  tag of the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, busy=0, counter and internal accumulators cleared. Takes effect immediately, including mid-operation; no response is produced for the aborted operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on the accept edge (req_valid & req_ready).
  - Latch op and tag.
  - Convert signed operands to magnitudes: a signed for MULH/MULHSU/DIV/REM; b signed for MULH/DIV/REM only.
  - Record the result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Clear the counter.
- Special cases, decided at accept; the unit goes IDLE -> DONE directly with resp_valid high one edge after accept:
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = req_a.
  - Signed overflow: DIV with a = 1<<(XLEN-1) and b = all ones gives result = 1<<(XLEN-1); REM gives 0.
- CALC performs BITS_PER_CYCLE steps per edge.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract over the XLEN-bit remainder and quotient.
  - The counter increments each edge; after the Nth CALC edge, go to FIX.
- FIX (one edge):
  - Apply two's-complement negation if the recorded sign is set.
  - Select the output: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Load resp_data/resp_rd, set resp_valid, go to DONE.
- Normal latency: resp_valid rises N+2 edges after the accept edge (34 for XLEN=32, BITS_PER_CYCLE=1; 10 for BITS_PER_CYCLE=4).
- DONE:
  - resp_valid, resp_data and resp_rd are held stable until resp_valid & resp_ready.
  - On that edge: resp_valid=0, go to IDLE. req_ready rises the cycle after.
  - No request is accepted while in DONE; there is no overlap.
- flush high at an edge in CALC, FIX or DONE: go to IDLE, resp_valid=0, no response. flush in IDLE is ignored, and it has priority over a simultaneous accept, so a request with flush high is not taken.
- Input operands need not remain stable after the accept edge.
- All arithmetic is modulo 2^XLEN except the 2*XLEN product; no X propagation out of resp_data in any state.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> resp_data=0xFFFFFFEB, resp_rd = issued tag, resp_valid exactly 34 edges after accept (BITS_PER_CYCLE=1).
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with resp_valid 1 edge after accept: DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: hold resp_ready low 5 cycles after resp_valid -> data and tag unchanged, req_ready stays 0; on release, one handshake, then req_ready=1 on the next cycle.
- flush at CALC cycle 10, and separately resetn pulsed low mid-CALC -> no resp_valid; unit in IDLE with busy=0; a following MUL 3x5 returns 15. Repeat the first test at BITS_PER_CYCLE=2 and 4 -> latency 18 / 10.
